// File: rtl/lo_hi_muldiv_unit.sv
// lo_hi_muldiv_unit: iterative radix-2 multiply/divide unit that owns the
// LO/HI architectural registers. Signed operations run on operand magnitudes
// and apply the sign correction in a final FIX cycle. MTLO/MTHI writes land
// on the next edge in any state, but a FIX write on the same edge takes priority.
module lo_hi_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             MtloW,
    input  logic             MthiW,
    input  logic [WIDTH-1:0] WriteDataW,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] LoOut,
    output logic [WIDTH-1:0] HiOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negation helpers
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd_q;     // mul: |multiplicand|; div: |divisor|
    logic               is_div_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               b_zero_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_lo_s;
    logic [WIDTH-1:0]   fix_hi_s;

    // Operand magnitudes at launch, one iteration step, and sign-corrected results
    always_comb begin
        a_neg_s  = ~OpE[0] & SrcAE[WIDTH-1];
        b_neg_s  = ~OpE[0] & SrcBE[WIDTH-1];
        a_mag_s  = a_neg_s ? neg_w(SrcAE) : SrcAE;
        b_mag_s  = b_neg_s ? neg_w(SrcBE) : SrcBE;

        sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, opnd_q};
        acc_d    = acc_q;
        if (is_div_q) begin
            if (rem_sh_s >= {1'b0, opnd_q}) begin
                acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_d = {sum_s, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end

        prod_s   = (sign_a_q ^ sign_b_q) ? neg_2w(acc_q) : acc_q;
        fix_lo_s = prod_s[WIDTH-1:0];
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            // A zero divisor leaves |A| as remainder, so the sign fix restores SrcAE
            fix_hi_s = sign_a_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
            if (b_zero_q) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else if (sign_a_q ^ sign_b_q) begin
                fix_lo_s = neg_w(acc_q[WIDTH-1:0]);
            end else begin
                fix_lo_s = acc_q[WIDTH-1:0];
            end
        end else begin
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and LO/HI registers with FIX-over-MT priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= {CW{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            lo_q     <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (MtloW) begin
                lo_q <= WriteDataW;
            end
            if (MthiW) begin
                hi_q <= WriteDataW;
            end
            case (state_q)
                S_IDLE: begin
                    if (StartE) begin
                        is_div_q <= OpE[1];
                        sign_a_q <= a_neg_s;
                        sign_b_q <= b_neg_s;
                        b_zero_q <= (SrcBE == {WIDTH{1'b0}});
                        opnd_q   <= OpE[1] ? b_mag_s : a_mag_s;
                        acc_q    <= {{WIDTH{1'b0}}, (OpE[1] ? a_mag_s : b_mag_s)};
                        count_q  <= CW'(WIDTH - 1);
                        dbz_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
                    if (count_q == {CW{1'b0}}) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo_q    <= fix_lo_s;
                    hi_q    <= fix_hi_s;
                    done_q  <= 1'b1;
                    dbz_q   <= is_div_q & b_zero_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign LoOut     = lo_q;
    assign HiOut     = hi_q;

endmodule

// File: tb/tb_lo_hi_muldiv_unit.sv
// Directed testbench for lo_hi_muldiv_unit with hand-computed expected values.
module tb_lo_hi_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        StartE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MtloW;
    logic        MthiW;
    logic [31:0] WriteDataW;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] LoOut;
    logic [31:0] HiOut;

    int n_tests;
    int n_fail;
    int lat;
    int bcnt;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    lo_hi_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartE     (StartE),
        .OpE        (OpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .MtloW      (MtloW),
        .MthiW      (MthiW),
        .WriteDataW (WriteDataW),
        .Busy       (Busy),
        .Done       (Done),
        .DivByZero  (DivByZero),
        .LoOut      (LoOut),
        .HiOut      (HiOut)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op, then wait (bounded) for Done; returns edges to Done and Busy-high samples
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat_o, output int busy_o);
        StartE = 1'b1;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        tick();
        StartE = 1'b0;
        lat_o  = 0;
        busy_o = Busy ? 1 : 0;
        while (!Done && lat_o < 100) begin
            tick();
            lat_o++;
            if (Busy) busy_o++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        StartE = 1'b0;
        OpE = 2'b00;
        SrcAE = 32'd0;
        SrcBE = 32'd0;
        MtloW = 1'b0;
        MthiW = 1'b0;
        WriteDataW = 32'd0;
        repeat (3) tick();
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_dbz", {63'd0, DivByZero}, 64'd0);
        check("rst_lohi", {HiOut, LoOut}, 64'd0);
        reset = 1'b0;
        tick();

        // 1. MULTU max*max, latency and Busy width
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_max", {HiOut, LoOut}, 64'hFFFF_FFFE_0000_0001);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy", 64'(bcnt), 64'd33);
        tick();
        check("done_pulse", {63'd0, Done}, 64'd0);

        // 2. Signed multiplies
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        check("mult_m3x5", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        check("mult_min2", {HiOut, LoOut}, 64'h4000_0000_0000_0000);

        // 3. Divides
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_m7d2", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        check("divu_100d7", {HiOut, LoOut}, {32'd2, 32'd14});
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_ovf", {HiOut, LoOut}, 64'h0000_0000_8000_0000);
        check("div_lat", 64'(lat), 64'd33);

        // 4. Divide by zero and its clearing
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, lat, bcnt);
        check("dbz_res", {HiOut, LoOut}, 64'h0000_1234_FFFF_FFFF);
        check("dbz_lat", 64'(lat), 64'd33);
        check("dbz_flag", {63'd0, DivByZero}, 64'd1);
        tick();
        check("dbz_hold", {63'd0, DivByZero}, 64'd1);
        run_op(OP_MULTU, 32'd1, 32'd1, lat, bcnt);
        check("dbz_clr", {63'd0, DivByZero}, 64'd0);

        // 5. Ignored start, MTLO during RUN, MTHI lost to FIX
        StartE = 1'b1;
        OpE = OP_MULTU;
        SrcAE = 32'd2;
        SrcBE = 32'd3;
        tick();
        StartE = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            StartE = (k == 5);
            OpE = (k == 5) ? OP_DIVU : OP_MULTU;
            SrcAE = (k == 5) ? 32'd100 : 32'd2;
            SrcBE = (k == 5) ? 32'd7 : 32'd3;
            MtloW = (k == 10);
            MthiW = (k == 33);
            WriteDataW = (k == 33) ? 32'h55 : 32'hAAAA;
            tick();
            StartE = 1'b0;
            MtloW = 1'b0;
            MthiW = 1'b0;
            if (k == 10) check("mtlo_run", {32'd0, LoOut}, {32'd0, 32'hAAAA});
        end
        check("ign_done", {63'd0, Done}, 64'd1);
        check("ign_res", {HiOut, LoOut}, {32'd0, 32'd6});
        tick();
        check("ign_busy", {63'd0, Busy}, 64'd0);

        // Start and MTHI together in IDLE: both take effect
        MthiW = 1'b1;
        WriteDataW = 32'h1357;
        StartE = 1'b1;
        OpE = OP_DIV;
        SrcAE = 32'd50;
        SrcBE = 32'd5;
        tick();
        MthiW = 1'b0;
        StartE = 1'b0;
        check("mt_start_hi", {32'd0, HiOut}, {32'd0, 32'h1357});
        check("mt_start_busy", {63'd0, Busy}, 64'd1);

        // 6. Async reset mid-DIV, then a clean DIVU
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, Busy}, 64'd0);
        check("rst_mid_lohi", {HiOut, LoOut}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        run_op(OP_DIVU, 32'd9, 32'd3, lat, bcnt);
        check("divu_9d3", {HiOut, LoOut}, {32'd0, 32'd3});
        check("divu_lat", 64'(lat), 64'd33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
